// File: rtl/keypad_seg7_display.sv
// keypad_seg7_display: multiplexed common-anode 7-segment driver with dead time between digit slots.
// Define KEYPAD_LEADING_ZERO_BLANK_EN to suppress leading zeros (digit 0 always shown).
module keypad_seg7_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS*4-1:0]   digits_in,
    input  logic                  load,
    input  logic                  blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [111:0] HEX = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    typedef enum logic {DEAD, DRIVE} state_t;
    logic [DIGITS*4-1:0] r_disp;
    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;
    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_wrap;
    logic                w_off;
    logic [PW-1:0]       w_pre_nxt;
    logic [IW-1:0]       w_idx_nxt;
    logic [3:0]          w_nib;
    logic [DIGITS-1:0]   w_lz;
    // r_state mirrors (r_pre < DEAD_CYCLES) so the slot phase is a single flop
    always_comb begin
        w_wrap      = r_pre == PW'(REFRESH_DIV - 1);
        w_pre_nxt   = w_wrap ? '0 : r_pre + 1'b1;
        w_idx_nxt   = w_wrap ? (r_idx == IW'(DIGITS - 1) ? '0 : r_idx + 1'b1) : r_idx;
        w_state_nxt = (w_pre_nxt < PW'(DEAD_CYCLES)) ? DEAD : DRIVE;
        w_nib       = 4'(r_disp >> {r_idx, 2'b00});
        w_off       = (r_state == DEAD) || blank || w_lz[r_idx];
    end
`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
    logic w_zrun;
    always_comb begin
        w_zrun = 1'b1;
        w_lz   = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_zrun  = w_zrun && (r_disp[4*i +: 4] == 4'h0);
            w_lz[i] = w_zrun;
        end
    end
`else
    assign w_lz = '0;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_disp  <= '0;
            r_pre   <= '0;
            r_idx   <= '0;
            r_state <= (DEAD_CYCLES > 0) ? DEAD : DRIVE;
            r_an    <= '1;
            r_seg   <= 7'h7F;
        end else begin
            r_disp  <= load ? digits_in : r_disp;
            r_pre   <= w_pre_nxt;
            r_idx   <= w_idx_nxt;
            r_state <= w_state_nxt;
            r_an    <= w_off ? '1 : ~(DIGITS'(1) << r_idx);
            r_seg   <= w_off ? 7'h7F : HEX[7*w_nib +: 7];
        end
    end
    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;
endmodule

// File: tb/tb_keypad_seg7_display.sv
// tb_keypad_seg7_display: directed checks of scan timing, loading, blanking and reset.
module tb_keypad_seg7_display;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    keypad_seg7_display #(.DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .load(load), .blank(blank),
        .an(an), .seg(seg), .dp(dp)
    );

    // one posedge passes; outputs are then read at the following negedge
    task automatic step;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0;
        load = 1'b0;
        blank = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset;
        do_reset;
        digits_in = 16'h8888;
        load = 1'b1;
        step;
        load = 1'b0;
        repeat (4) step;
        #2;
        reset = 1'b0;
        load = 1'b1;
        digits_in = 16'hFFFF;
        #1;
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL reset_async_an got=%h exp=F", an); end
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL reset_async_seg got=%h exp=7F", seg); end
        checks++;
        if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
        @(negedge clk);
        load = 1'b0;
        reset = 1'b1;
        cyc = 0;
        for (int k = 0; k < 8; k++) begin
            step;
            checks++;
            if (an !== ((cyc < 3) ? 4'hF : 4'hE)) begin
                errors++; $display("FAIL reset_release_an cyc=%0d got=%h exp=%h", cyc, an, (cyc < 3) ? 4'hF : 4'hE);
            end
            checks++;
            if (seg !== ((cyc < 3) ? 7'h7F : 7'h40)) begin
                errors++; $display("FAIL reset_release_seg cyc=%0d got=%h exp=%h", cyc, seg, (cyc < 3) ? 7'h7F : 7'h40);
            end
        end
    endtask

    task automatic test_scan;
        logic [3:0] an_t [4];
        logic [6:0] seg_t [4];
        logic [3:0] ea;
        logic [6:0] es;
        int p, i;
        an_t = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_t = '{7'h0E, 7'h08, 7'h24, 7'h79};
        do_reset;
        digits_in = 16'h12AF;
        load = 1'b1;
        for (int k = 0; k < 33; k++) begin
            step;
            load = 1'b0;
            p = (cyc - 1) % 8;
            i = ((cyc - 1) / 8) % 4;
            ea = (p < 2) ? 4'hF : an_t[i];
            es = (p < 2) ? 7'h7F : seg_t[i];
            checks++;
            if (an !== ea) begin errors++; $display("FAIL scan_an cyc=%0d got=%h exp=%h", cyc, an, ea); end
            checks++;
            if (seg !== es) begin errors++; $display("FAIL scan_seg cyc=%0d got=%h exp=%h", cyc, seg, es); end
        end
    endtask

    task automatic test_hold;
        logic [3:0] an_t [4];
        logic [6:0] seg_t [4];
        logic [3:0] ea;
        logic [6:0] es;
        int p, i;
`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
        an_t = '{4'hE, 4'hF, 4'hF, 4'hF};
`else
        an_t = '{4'hE, 4'hD, 4'hB, 4'h7};
`endif
        seg_t = '{7'h30, 7'h40, 7'h40, 7'h40};
        do_reset;
        digits_in = 16'h0003;
        load = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step;
            load = 1'b0;
            digits_in = 16'hFFFF;
            p = (cyc - 1) % 8;
            i = ((cyc - 1) / 8) % 4;
            ea = (p < 2) ? 4'hF : an_t[i];
            es = (p < 2) ? 7'h7F : seg_t[i];
            checks++;
            if (an !== ea) begin errors++; $display("FAIL hold_an cyc=%0d got=%h exp=%h", cyc, an, ea); end
            if (p < 2 || ea != 4'hF) begin
                checks++;
                if (seg !== es) begin errors++; $display("FAIL hold_seg cyc=%0d got=%h exp=%h", cyc, seg, es); end
            end
        end
    endtask

    task automatic test_blank;
        logic [3:0] an_t [4];
        logic [6:0] seg_t [4];
        logic [3:0] ea;
        logic [6:0] es;
        logic dark;
        int p, i;
        an_t = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_t = '{7'h0E, 7'h08, 7'h24, 7'h79};
        do_reset;
        digits_in = 16'h12AF;
        for (int k = 0; k < 48; k++) begin
            load = (cyc == 0);
            blank = (cyc >= 10 && cyc < 30);
            step;
            p = (cyc - 1) % 8;
            i = ((cyc - 1) / 8) % 4;
            dark = (p < 2) || (cyc >= 11 && cyc <= 30);
            ea = dark ? 4'hF : an_t[i];
            es = dark ? 7'h7F : seg_t[i];
            checks++;
            if (an !== ea) begin errors++; $display("FAIL blank_an cyc=%0d got=%h exp=%h", cyc, an, ea); end
            checks++;
            if (seg !== es) begin errors++; $display("FAIL blank_seg cyc=%0d got=%h exp=%h", cyc, seg, es); end
        end
        blank = 1'b0;
    endtask

    task automatic test_leading_zero;
        logic [3:0] an_t [2][4];
        logic [6:0] seg_t [2][4];
        logic [3:0] ea;
        logic [6:0] es;
        int p, i, w;
`ifdef KEYPAD_LEADING_ZERO_BLANK_EN
        an_t = '{'{4'hE, 4'hD, 4'hF, 4'hF}, '{4'hE, 4'hF, 4'hF, 4'hF}};
`else
        an_t = '{'{4'hE, 4'hD, 4'hB, 4'h7}, '{4'hE, 4'hD, 4'hB, 4'h7}};
`endif
        seg_t = '{'{7'h40, 7'h30, 7'h40, 7'h40}, '{7'h40, 7'h40, 7'h40, 7'h40}};
        do_reset;
        for (int k = 0; k < 64; k++) begin
            load = (cyc == 0 || cyc == 32);
            digits_in = (cyc < 32) ? 16'h0030 : 16'h0000;
            step;
            p = (cyc - 1) % 8;
            i = ((cyc - 1) / 8) % 4;
            w = (cyc > 32) ? 1 : 0;
            ea = (p < 2) ? 4'hF : an_t[w][i];
            es = (p < 2) ? 7'h7F : seg_t[w][i];
            checks++;
            if (an !== ea) begin errors++; $display("FAIL lz_an cyc=%0d got=%h exp=%h", cyc, an, ea); end
            if (p < 2 || ea != 4'hF) begin
                checks++;
                if (seg !== es) begin errors++; $display("FAIL lz_seg cyc=%0d got=%h exp=%h", cyc, seg, es); end
            end
        end
        load = 1'b0;
    endtask

    task automatic test_wrap_load;
        logic [3:0] an_t [4];
        logic [6:0] old_t [4];
        logic [6:0] new_t [4];
        logic [3:0] ea;
        logic [6:0] es;
        int p, i;
        an_t = '{4'hE, 4'hD, 4'hB, 4'h7};
        old_t = '{7'h0E, 7'h08, 7'h24, 7'h79};
        new_t = '{7'h00, 7'h78, 7'h02, 7'h12};
        do_reset;
        for (int k = 0; k < 24; k++) begin
            load = (cyc == 0 || cyc == 7);
            digits_in = (cyc == 0) ? 16'h12AF : 16'h5678;
            step;
            p = (cyc - 1) % 8;
            i = ((cyc - 1) / 8) % 4;
            ea = (p < 2) ? 4'hF : an_t[i];
            es = (p < 2) ? 7'h7F : ((cyc >= 9) ? new_t[i] : old_t[i]);
            checks++;
            if (an !== ea) begin errors++; $display("FAIL wrap_an cyc=%0d got=%h exp=%h", cyc, an, ea); end
            checks++;
            if (seg !== es) begin errors++; $display("FAIL wrap_seg cyc=%0d got=%h exp=%h", cyc, seg, es); end
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [3:0] ea;
        logic [6:0] es;
        do_reset;
        for (int k = 0; k < 8; k++) begin
            load = (cyc < 2);
            digits_in = (cyc == 0) ? 16'h1111 : 16'h2222;
            step;
            ea = (cyc < 3) ? 4'hF : 4'hE;
            es = (cyc < 3) ? 7'h7F : 7'h24;
            checks++;
            if (an !== ea) begin errors++; $display("FAIL b2b_an cyc=%0d got=%h exp=%h", cyc, an, ea); end
            checks++;
            if (seg !== es) begin errors++; $display("FAIL b2b_seg cyc=%0d got=%h exp=%h", cyc, seg, es); end
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset;
        test_scan;
        test_hold;
        test_blank;
        test_leading_zero;
        test_wrap_load;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
